pipelined_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter. It is the next generation of the team's 16-bit combinational shifter, generalised to any power-of-two width.
- Supports logical, arithmetic and rotate modes in both directions, and produces Z/N/C/V flags (V is now real).
- Streams operands through log2(WIDTH) registered shift stages with valid/ready handshakes on both sides. Sits between the ALU operand mux and the writeback/flag register.

---
 rtl/pipelined_shifter_if.sv | 36 +++
 rtl/pipelined_shifter.sv | 175 +++++++++++++++++
 tb/tb_pipelined_shifter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_shifter_if.sv
// ============================================================================
// Module      : pipelined_shifter_if
// Description : Operand/result handshake bundle for the pipelined shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipelined_shifter_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic [2:0]       in_func;
    logic [SHW-1:0]   in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_flags;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_dir, in_func, in_shamt, out_ready,
        input  in_ready, out_valid, out_data, out_flags, out_err
    );

    modport slave (
        input  in_valid, in_data, in_dir, in_func, in_shamt, out_ready,
        output in_ready, out_valid, out_data, out_flags, out_err
    );
endinterface

`default_nettype wire

// File: rtl/pipelined_shifter.sv
// ============================================================================
// Module      : pipelined_shifter
// Description : log2(WIDTH)-stage pipelined barrel shifter (LOG/ARI/ROT, both
//               directions) producing Z/N/C/V flags, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_shifter #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        flush,
    pipelined_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] c_FUNC_LOG = 3'b100;
    localparam logic [2:0] c_FUNC_ARI = 3'b010;
    localparam logic [2:0] c_FUNC_ROT = 3'b001;

    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d,
                                                 input logic dir,
                                                 input logic [2:0] fn,
                                                 input int sh);
        logic [WIDTH-1:0] r;
        if (fn == c_FUNC_ROT)
            r = dir ? ((d >> sh) | (d << (WIDTH - sh)))
                    : ((d << sh) | (d >> (WIDTH - sh)));
        else if (fn == c_FUNC_ARI && dir)
            r = $unsigned($signed(d) >>> sh);
        else
            r = dir ? (d >> sh) : (d << sh);
        return r;
    endfunction

    // Last bit to leave the word on this step; composes across stages.
    function automatic logic f_carry(input logic [WIDTH-1:0] d,
                                     input logic dir,
                                     input int sh);
        logic [WIDTH-1:0] t;
        t = dir ? (d >> (sh - 1)) : (d >> (WIDTH - sh));
        return t[0];
    endfunction

    function automatic logic f_sign_change(input logic [WIDTH-1:0] d,
                                           input int sh);
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] t;
        m = ~({WIDTH{1'b1}} >> (sh + 1));
        t = d & m;
        return (t != '0) && (t != m);
    endfunction

    logic             valid_q [SHW];
    logic [WIDTH-1:0] data_q  [SHW];
    logic             dir_q   [SHW];
    logic [2:0]       func_q  [SHW];
    logic [SHW-1:0]   shamt_q [SHW];
    logic             c_q     [SHW];
    logic             v_q     [SHW];
    logic             err_q   [SHW];
    logic             z_q;
    logic             n_q;

    logic             valid_d [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic             dir_d   [SHW];
    logic [2:0]       func_d  [SHW];
    logic [SHW-1:0]   shamt_d [SHW];
    logic             c_d     [SHW];
    logic             v_d     [SHW];
    logic             err_d   [SHW];

    logic w_illegal;
    logic w_adv;

    always_comb begin
        w_illegal = 1'b1;
        case (bus.in_func)
            c_FUNC_LOG, c_FUNC_ARI, c_FUNC_ROT: w_illegal = 1'b0;
            default:                            w_illegal = 1'b1;
        endcase
    end

    assign w_adv        = !valid_q[SHW-1] || bus.out_ready;
    assign bus.in_ready = w_adv;

    for (genvar k = 0; k < SHW; k++) begin : g_slot
        localparam int SH = 1 << (SHW - 1 - k);

        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_data;
        logic             w_src_dir;
        logic [2:0]       w_src_func;
        logic [SHW-1:0]   w_src_shamt;
        logic             w_src_c;
        logic             w_src_v;
        logic             w_src_err;
        logic             w_en;

        if (k == 0) begin : g_head
            // Illegal func forces a zero shift so data passes through with C=V=0.
            assign w_src_valid = bus.in_valid;
            assign w_src_data  = bus.in_data;
            assign w_src_dir   = bus.in_dir;
            assign w_src_func  = bus.in_func;
            assign w_src_shamt = w_illegal ? '0 : bus.in_shamt;
            assign w_src_c     = 1'b0;
            assign w_src_v     = 1'b0;
            assign w_src_err   = w_illegal;
        end else begin : g_tail
            assign w_src_valid = valid_q[k-1];
            assign w_src_data  = data_q[k-1];
            assign w_src_dir   = dir_q[k-1];
            assign w_src_func  = func_q[k-1];
            assign w_src_shamt = shamt_q[k-1];
            assign w_src_c     = c_q[k-1];
            assign w_src_v     = v_q[k-1];
            assign w_src_err   = err_q[k-1];
        end

        assign w_en       = w_src_shamt[SHW-1-k];
        assign valid_d[k] = w_src_valid;
        assign data_d[k]  = w_en ? f_shift(w_src_data, w_src_dir, w_src_func, SH) : w_src_data;
        assign dir_d[k]   = w_src_dir;
        assign func_d[k]  = w_src_func;
        assign shamt_d[k] = w_src_shamt;
        assign c_d[k]     = w_en ? f_carry(w_src_data, w_src_dir, SH) : w_src_c;
        assign v_d[k]     = w_src_v || (w_en && (w_src_func == c_FUNC_ARI) && !w_src_dir
                                        && f_sign_change(w_src_data, SH));
        assign err_d[k]   = w_src_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SHW; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                dir_q[k]   <= 1'b0;
                func_q[k]  <= '0;
                shamt_q[k] <= '0;
                c_q[k]     <= 1'b0;
                v_q[k]     <= 1'b0;
                err_q[k]   <= 1'b0;
            end
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < SHW; k++) valid_q[k] <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < SHW; k++) begin
                valid_q[k] <= valid_d[k];
                data_q[k]  <= data_d[k];
                dir_q[k]   <= dir_d[k];
                func_q[k]  <= func_d[k];
                shamt_q[k] <= shamt_d[k];
                c_q[k]     <= c_d[k];
                v_q[k]     <= v_d[k];
                err_q[k]   <= err_d[k];
            end
            z_q <= (data_d[SHW-1] == '0);
            n_q <= data_d[SHW-1][WIDTH-1];
        end
    end

    assign bus.out_valid = valid_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];
    assign bus.out_flags = {z_q, n_q, c_q[SHW-1], v_q[SHW-1]};
    assign bus.out_err   = err_q[SHW-1];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
// ============================================================================
// Module      : tb_pipelined_shifter
// Description : Directed self-checking bench for pipelined_shifter, WIDTH=32/8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_shifter;
    logic clk;
    logic reset_n;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [31:0] d;  logic dir; logic [2:0] fn; logic [4:0] sh;
        logic [31:0] ed; logic [3:0] ef; logic ee;
    } vec32_t;

    typedef struct {
        logic [7:0] d;  logic dir; logic [2:0] fn; logic [2:0] sh;
        logic [7:0] ed; logic [3:0] ef; logic ee;
    } vec8_t;

    pipelined_shifter_if #(.WIDTH(32)) b32 ();
    pipelined_shifter_if #(.WIDTH(8))  b8  ();

    pipelined_shifter #(.WIDTH(32)) u_dut32 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b32));
    pipelined_shifter #(.WIDTH(8))  u_dut8  (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation, waits for its result; lat = -1 if none appears.
    task automatic drive_op32(input logic [31:0] d, input logic dir, input logic [2:0] fn,
                              input logic [4:0] sh, output logic [31:0] od,
                              output logic [3:0] of, output logic oe, output int lat);
        b32.out_ready = 1'b1;
        b32.in_valid  = 1'b1;
        b32.in_data   = d;
        b32.in_dir    = dir;
        b32.in_func   = fn;
        b32.in_shamt  = sh;
        tick();
        b32.in_valid = 1'b0;
        lat = 1;
        while (!b32.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!b32.out_valid) lat = -1;
        od = b32.out_data;
        of = b32.out_flags;
        oe = b32.out_err;
        tick();
    endtask

    task automatic drive_op8(input logic [7:0] d, input logic dir, input logic [2:0] fn,
                             input logic [2:0] sh, output logic [7:0] od,
                             output logic [3:0] of, output logic oe, output int lat);
        b8.out_ready = 1'b1;
        b8.in_valid  = 1'b1;
        b8.in_data   = d;
        b8.in_dir    = dir;
        b8.in_func   = fn;
        b8.in_shamt  = sh;
        tick();
        b8.in_valid = 1'b0;
        lat = 1;
        while (!b8.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!b8.out_valid) lat = -1;
        od = b8.out_data;
        of = b8.out_flags;
        oe = b8.out_err;
        tick();
    endtask

    task automatic test_reset();
        #7;
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", b32.out_valid); end
        checks++; if (b32.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", b32.out_data); end
        checks++; if (b32.out_flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", b32.out_flags); end
        checks++; if (b32.out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", b32.out_err); end
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", b32.in_ready); end
        checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b want 0", b8.out_valid); end
        #5 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_modes();
        vec32_t t [9];
        logic [31:0] od; logic [3:0] of; logic oe; int lat;
        t = '{'{32'h8000_0001, 1'b1, 3'b010, 5'd4,  32'hF800_0000, 4'b0100, 1'b0},
              '{32'h0000_0001, 1'b1, 3'b001, 5'd1,  32'h8000_0000, 4'b0110, 1'b0},
              '{32'h8000_0000, 1'b0, 3'b001, 5'd1,  32'h0000_0001, 4'b0010, 1'b0},
              '{32'h4000_0000, 1'b0, 3'b100, 5'd2,  32'h0000_0000, 4'b1010, 1'b0},
              '{32'h4000_0000, 1'b0, 3'b010, 5'd1,  32'h8000_0000, 4'b0101, 1'b0},
              '{32'hFFFF_FFFF, 1'b1, 3'b100, 5'd31, 32'h0000_0001, 4'b0010, 1'b0},
              '{32'hC000_0000, 1'b0, 3'b010, 5'd1,  32'h8000_0000, 4'b0110, 1'b0},
              '{32'h1234_5678, 1'b0, 3'b001, 5'd31, 32'h091A_2B3C, 4'b0000, 1'b0},
              '{32'h8000_0000, 1'b1, 3'b010, 5'd31, 32'hFFFF_FFFF, 4'b0100, 1'b0}};
        for (int i = 0; i < 9; i++) begin
            drive_op32(t[i].d, t[i].dir, t[i].fn, t[i].sh, od, of, oe, lat);
            checks++; if (lat != 5) begin errors++; $display("FAIL mode%0d_latency: got %0d want 5", i, lat); end
            checks++; if (od !== t[i].ed) begin errors++; $display("FAIL mode%0d_data: got %h want %h", i, od, t[i].ed); end
            checks++; if (of !== t[i].ef) begin errors++; $display("FAIL mode%0d_flags: got %b want %b", i, of, t[i].ef); end
            checks++; if (oe !== t[i].ee) begin errors++; $display("FAIL mode%0d_err: got %b want %b", i, oe, t[i].ee); end
        end
    endtask

    task automatic test_shamt_zero();
        logic [31:0] od; logic [3:0] of; logic oe; int lat;
        logic [2:0] fn;
        for (int m = 0; m < 3; m++) begin
            for (int dr = 0; dr < 2; dr++) begin
                fn = 3'b100 >> m;
                drive_op32(32'h8000_00F0, dr[0], fn, 5'd0, od, of, oe, lat);
                checks++; if (od !== 32'h8000_00F0) begin errors++; $display("FAIL shamt0_f%b_d%0d_data: got %h want 800000f0", fn, dr, od); end
                checks++; if (of !== 4'b0100) begin errors++; $display("FAIL shamt0_f%b_d%0d_flags: got %b want 0100", fn, dr, of); end
            end
        end
    endtask

    task automatic test_illegal_func();
        vec32_t t [3];
        logic [31:0] od; logic [3:0] of; logic oe; int lat;
        t = '{'{32'h1234_5678, 1'b1, 3'b011, 5'd5, 32'h1234_5678, 4'b0000, 1'b1},
              '{32'h1234_5678, 1'b1, 3'b100, 5'd4, 32'h0123_4567, 4'b0010, 1'b0},
              '{32'hFFFF_0000, 1'b0, 3'b111, 5'd3, 32'hFFFF_0000, 4'b0100, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            drive_op32(t[i].d, t[i].dir, t[i].fn, t[i].sh, od, of, oe, lat);
            checks++; if (od !== t[i].ed) begin errors++; $display("FAIL illegal%0d_data: got %h want %h", i, od, t[i].ed); end
            checks++; if (of !== t[i].ef) begin errors++; $display("FAIL illegal%0d_flags: got %b want %b", i, of, t[i].ef); end
            checks++; if (oe !== t[i].ee) begin errors++; $display("FAIL illegal%0d_err: got %b want %b", i, oe, t[i].ee); end
            checks++; if (lat != 5) begin errors++; $display("FAIL illegal%0d_latency: got %0d want 5", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [8];
        logic [31:0] held;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        exp_q = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
        held = '0;
        b32.in_dir   = 1'b0;
        b32.in_func  = 3'b100;
        b32.in_shamt = 5'd4;
        while (got < 8 && cyc < 40) begin
            b32.in_valid  = (sent < 8);
            b32.in_data   = 32'(sent + 1);
            b32.out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (cyc >= 6 && cyc <= 8) begin
                checks++; if (b32.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_c%0d: got %b want 0", cyc, b32.in_ready); end
                if (cyc == 6) held = b32.out_data;
                else begin
                    checks++; if (b32.out_data !== held) begin errors++; $display("FAIL stall_hold_c%0d: got %h want %h", cyc, b32.out_data, held); end
                end
            end
            if (b32.out_valid && b32.out_ready) begin
                checks++;
                if (b32.out_data !== exp_q[got] || b32.out_flags !== 4'b0000) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %h/%b want %h/0000", got, b32.out_data, b32.out_flags, exp_q[got]);
                end
                got++;
            end
            if (b32.in_valid && b32.in_ready) sent++;
            tick();
            cyc++;
        end
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
        tick();
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra: got out_valid %b want 0", b32.out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] od; logic [3:0] of; logic oe; int lat;
        int seen = 0;
        b32.out_ready = 1'b1;
        b32.in_dir    = 1'b0;
        b32.in_func   = 3'b100;
        b32.in_shamt  = 5'd1;
        for (int i = 0; i < 3; i++) begin
            b32.in_valid = 1'b1;
            b32.in_data  = 32'(i + 5);
            tick();
        end
        flush = 1'b1;
        b32.in_data = 32'h0000_DEAD;
        #1;
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", b32.in_ready); end
        tick();
        flush = 1'b0;
        b32.in_valid = 1'b0;
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", b32.out_valid); end
        for (int i = 0; i < 10; i++) begin
            if (b32.out_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_leak: got %0d results want 0", seen); end
        drive_op32(32'h8000_0000, 1'b1, 3'b100, 5'd31, od, of, oe, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL flush_fresh_latency: got %0d want 5", lat); end
        checks++; if (od !== 32'h0000_0001) begin errors++; $display("FAIL flush_fresh_data: got %h want 00000001", od); end
        checks++; if (of !== 4'b0000) begin errors++; $display("FAIL flush_fresh_flags: got %b want 0000", of); end
    endtask

    task automatic test_reset_in_flight();
        logic [31:0] od; logic [3:0] of; logic oe; int lat;
        int seen = 0;
        b32.out_ready = 1'b1;
        b32.in_dir    = 1'b0;
        b32.in_func   = 3'b100;
        b32.in_shamt  = 5'd1;
        for (int i = 0; i < 3; i++) begin
            b32.in_valid = 1'b1;
            b32.in_data  = 32'h0000_000F;
            tick();
        end
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b0;
        tick();
        tick();
        checks++; if (b32.out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", b32.out_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", b32.out_valid); end
        checks++; if (b32.out_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", b32.out_data); end
        checks++; if (b32.out_flags !== 4'h0) begin errors++; $display("FAIL rst_flags: got %b want 0000", b32.out_flags); end
        #2 reset_n = 1'b1;
        b32.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (b32.out_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_leak: got %0d results want 0", seen); end
        drive_op32(32'h0000_0003, 1'b1, 3'b001, 5'd2, od, of, oe, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL rst_fresh_latency: got %0d want 5", lat); end
        checks++; if (od !== 32'hC000_0000) begin errors++; $display("FAIL rst_fresh_data: got %h want c0000000", od); end
        checks++; if (of !== 4'b0110) begin errors++; $display("FAIL rst_fresh_flags: got %b want 0110", of); end
    endtask

    task automatic test_width8();
        vec8_t t [6];
        logic [7:0] od; logic [3:0] of; logic oe; int lat;
        t = '{'{8'h81, 1'b1, 3'b010, 3'd4, 8'hF8, 4'b0100, 1'b0},
              '{8'h80, 1'b0, 3'b001, 3'd1, 8'h01, 4'b0010, 1'b0},
              '{8'h40, 1'b0, 3'b010, 3'd1, 8'h80, 4'b0101, 1'b0},
              '{8'hFF, 1'b1, 3'b100, 3'd7, 8'h01, 4'b0010, 1'b0},
              '{8'hA5, 1'b0, 3'b000, 3'd3, 8'hA5, 4'b0100, 1'b1},
              '{8'h3C, 1'b1, 3'b001, 3'd2, 8'h0F, 4'b0000, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            drive_op8(t[i].d, t[i].dir, t[i].fn, t[i].sh, od, of, oe, lat);
            checks++; if (lat != 3) begin errors++; $display("FAIL w8_%0d_latency: got %0d want 3", i, lat); end
            checks++; if (od !== t[i].ed) begin errors++; $display("FAIL w8_%0d_data: got %h want %h", i, od, t[i].ed); end
            checks++; if (of !== t[i].ef) begin errors++; $display("FAIL w8_%0d_flags: got %b want %b", i, of, t[i].ef); end
            checks++; if (oe !== t[i].ee) begin errors++; $display("FAIL w8_%0d_err: got %b want %b", i, oe, t[i].ee); end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        b32.in_valid  = 1'b0;
        b32.in_data   = '0;
        b32.in_dir    = 1'b0;
        b32.in_func   = 3'b100;
        b32.in_shamt  = '0;
        b32.out_ready = 1'b1;
        b8.in_valid   = 1'b0;
        b8.in_data    = '0;
        b8.in_dir     = 1'b0;
        b8.in_func    = 3'b100;
        b8.in_shamt   = '0;
        b8.out_ready  = 1'b1;

        test_reset();
        test_modes();
        test_shamt_zero();
        test_illegal_func();
        test_back_to_back();
        test_flush();
        test_reset_in_flight();
        test_width8();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
